// File: rtl/branch_pkg.sv
// branch_pkg: branch type encodings and BHT helper functions
package branch_pkg;
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_BEQ  = 3'd2,
    BR_BNE  = 3'd3,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_CBZ  = 3'd6,
    BR_CBNZ = 3'd7
  } br_type_e;

  // Word-aligned PCs: drop the two low bits, keep log2(depth) bits above them
  function automatic int bht_idx(input logic [63:0] pc, input int depth);
    return int'(pc[33:2]) & (depth - 1);
  endfunction

  function automatic int bht_rst_val(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: raw taken/not-taken outcome for each branch type
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        ex_type,
  input  logic              n,
  input  logic              z,
  input  logic              v,
  input  logic [DATA_W-1:0] ex_reg,
  output logic              taken
);
  always_comb begin
    taken = 1'b0;
    case (br_type_e'(ex_type))
      BR_B:    taken = 1'b1;
      BR_BEQ:  taken = z;
      BR_BNE:  taken = !z;
      BR_BLT:  taken = n != v;
      BR_BGE:  taken = n == v;
      BR_CBZ:  taken = ex_reg == '0;
      BR_CBNZ: taken = ex_reg != '0;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: EX branch resolution, BHT prediction, registered
// redirect on mispredict and saturating branch statistics
module branch_resolve_predict
  import branch_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int PC_W      = 64,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_W     = 2,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_kill,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [2:0]        ex_type,
  input  logic              ex_pred_taken,
  input  logic              N,
  input  logic              Z,
  input  logic              V,
  input  logic              C,
  input  logic [DATA_W-1:0] ex_reg,
  output logic              ex_taken,
  output logic              flush,
  output logic              flush_to_target,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);
  localparam int IW = $clog2(BHT_DEPTH);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(bht_rst_val(CTR_W));

  logic [CTR_W-1:0]  bht_q [BHT_DEPTH];
  logic [CTR_W-1:0]  ctr_ex, ctr_d;
  logic [IW-1:0]     if_idx, ex_idx;
  logic              resolve, raw_taken, mispred, flush_q, ftt_q, ftt_d, unused_c;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .ex_type (ex_type),
    .n       (N),
    .z       (Z),
    .v       (V),
    .ex_reg  (ex_reg),
    .taken   (raw_taken)
  );

  // Carry flag participates in no LEGv8 branch condition handled here
  assign unused_c      = C;
  assign if_idx        = IW'(bht_idx(64'(if_pc), BHT_DEPTH));
  assign ex_idx        = IW'(bht_idx(64'(ex_pc), BHT_DEPTH));
  assign if_pred_taken = bht_q[if_idx][CTR_W-1];
  assign resolve       = ex_valid && !ex_kill && ex_type != BR_NONE;
  assign ex_taken      = resolve && raw_taken;
  assign mispred       = resolve && (ex_taken != ex_pred_taken);

  always_comb begin
    ctr_ex        = bht_q[ex_idx];
    ctr_d         = ex_taken ? (ctr_ex == CTR_MAX ? ctr_ex : ctr_ex + 1'b1)
                             : (ctr_ex == '0 ? ctr_ex : ctr_ex - 1'b1);
    ftt_d         = mispred ? ex_taken : ftt_q;
    branch_cnt_d  = stat_clr ? '0 : branch_cnt_q + STAT_W'(resolve && branch_cnt_q != '1);
    mispred_cnt_d = stat_clr ? '0 : mispred_cnt_q + STAT_W'(mispred && mispred_cnt_q != '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_RST;
      flush_q       <= 1'b0;
      ftt_q         <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve) bht_q[ex_idx] <= ctr_d;
      flush_q       <= mispred;
      ftt_q         <= ftt_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign flush           = flush_q;
  assign flush_to_target = ftt_q;
  assign branch_cnt      = branch_cnt_q;
  assign mispred_cnt     = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb_branch_resolve_predict: scoreboard bench with a reference BHT/stat model
module tb_branch_resolve_predict;
  localparam int SW = 4;
  logic          clk = 0, rst = 1;
  logic [63:0]   if_pc = 0, ex_pc = 0, ex_reg = 0;
  logic          if_pred_taken, ex_valid = 0, ex_kill = 0, ex_pred_taken = 0;
  logic [2:0]    ex_type = 0;
  logic          N = 0, Z = 0, V = 0, C = 0, stat_clr = 0;
  logic          ex_taken, flush, flush_to_target;
  logic [SW-1:0] branch_cnt, mispred_cnt;

  branch_resolve_predict #(.STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_kill(ex_kill), .ex_pc(ex_pc), .ex_type(ex_type),
    .ex_pred_taken(ex_pred_taken), .N(N), .Z(Z), .V(V), .C(C), .ex_reg(ex_reg),
    .ex_taken(ex_taken), .flush(flush), .flush_to_target(flush_to_target),
    .stat_clr(stat_clr), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [1:0] m_bht [64];
  int m_br = 0, m_mp = 0;
  logic m_ftt = 0;
  logic [1:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_cond(input logic [2:0] t, input logic n, input logic z,
                                  input logic v, input logic [63:0] r);
    case (t)
      3'd1: return 1'b1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return n ^ v;
      3'd5: return !(n ^ v);
      3'd6: return r == 0;
      3'd7: return r != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_br = 0; m_mp = 0; m_ftt = 0;
    sb_q.delete();
  endtask

  task automatic drv(input logic [2:0] t, input logic [63:0] pc, input logic pred,
                     input logic n, input logic z, input logic v, input logic [63:0] r,
                     input logic kill, input logic clr);
    logic res, tk, mp;
    logic [1:0] e;
    int ix;
    @(negedge clk);
    ex_valid = 1; ex_kill = kill; ex_pc = pc; if_pc = pc; ex_type = t;
    ex_pred_taken = pred; N = n; Z = z; V = v; C = 1'($urandom); ex_reg = r; stat_clr = clr;
    ix = int'(pc[7:2]);
    res = !kill && t != 0;
    tk = res && m_cond(t, n, z, v, r);
    mp = res && (tk != pred);
    #1;
    chk("ex_taken", 64'(ex_taken), 64'(tk));
    chk("if_pred_pre", 64'(if_pred_taken), 64'(m_bht[ix][1]));
    m_ftt = mp ? tk : m_ftt;
    sb_q.push_back({mp, m_ftt});
    if (res) m_bht[ix] = tk ? (m_bht[ix] == 2'b11 ? 2'b11 : m_bht[ix] + 2'b01)
                            : (m_bht[ix] == 2'b00 ? 2'b00 : m_bht[ix] - 2'b01);
    m_br = clr ? 0 : (res && m_br < 15 ? m_br + 1 : m_br);
    m_mp = clr ? 0 : (mp && m_mp < 15 ? m_mp + 1 : m_mp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("flush", 64'(flush), 64'(e[1]));
    chk("flush_to_target", 64'(flush_to_target), 64'(e[0]));
    chk("branch_cnt", 64'(branch_cnt), 64'(m_br));
    chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mp));
    chk("if_pred_post", 64'(if_pred_taken), 64'(m_bht[ix][1]));
    ex_valid = 0; ex_kill = 0; stat_clr = 0;
  endtask

  initial begin
    m_reset();
    if_pc = 64'h40;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_pred_40", 64'(if_pred_taken), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_ftt", 64'(flush_to_target), 64'd0);
    chk("rst_br", 64'(branch_cnt), 64'd0);
    // BEQ taken against a not-taken prediction
    drv(3'd2, 64'h40, 0, 0, 1, 0, 0, 0, 0);
    chk("beq_bht16", 64'(m_bht[16]), 64'd2);
    chk("beq_flush_abs", 64'(flush), 64'd1);
    drv(3'd7, 64'h44, 1, 0, 0, 0, 64'd0, 0, 0);
    drv(3'd6, 64'h48, 1, 0, 0, 0, 64'd0, 0, 0);
    drv(3'd4, 64'h4c, 0, 1, 0, 0, 64'd5, 0, 0);
    drv(3'd5, 64'h50, 1, 1, 0, 1, 64'd5, 0, 0);
    drv(3'd5, 64'h54, 1, 0, 0, 1, 64'd5, 0, 0);
    for (int i = 0; i < 5; i++) drv(3'd1, 64'h100, i[0], 0, 0, 0, 0, 0, 0);
    chk("sat_hi", 64'(m_bht[0]), 64'd3);
    for (int i = 0; i < 2; i++) drv(3'd2, 64'h80, 1, 0, 1, 0, 0, 0, 0);
    drv(3'd3, 64'h84, 0, 0, 0, 0, 0, 1, 0);
    drv(3'd0, 64'h88, 1, 0, 0, 0, 0, 0, 0);
    drv(3'd1, 64'h8c, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_br_abs", 64'(branch_cnt), 64'd0);
    for (int i = 0; i < 20; i++) drv(3'd1, 64'(i * 4), 0, 0, 0, 0, 0, 0, 0);
    chk("mp_sat_abs", 64'(mispred_cnt), 64'd15);
    drv(3'd0, 64'h0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++)
      drv(3'($urandom_range(0, 7)), 64'($urandom_range(0, 255)) << 2, 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 64'($urandom_range(0, 2)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    for (int i = 0; i < 6; i++) drv(3'd1, 64'h10, 0, 0, 0, 0, 0, 0, 0);
    // Asynchronous reset between edges while a mispredicting resolve is pending
    @(negedge clk);
    ex_valid = 1; ex_type = 3'd1; ex_pred_taken = 0; ex_pc = 64'h10;
    #2 rst = 1;
    #1;
    m_reset();
    chk("arst_flush", 64'(flush), 64'd0);
    chk("arst_ftt", 64'(flush_to_target), 64'd0);
    chk("arst_br", 64'(branch_cnt), 64'd0);
    chk("arst_mp", 64'(mispred_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_br", 64'(branch_cnt), 64'd0);
    chk("arst_hold_flush", 64'(flush), 64'd0);
    for (int i = 0; i < 64; i++) begin
      if_pc = 64'(i * 4);
      #1 chk("arst_pred", 64'(if_pred_taken), 64'd0);
    end
    ex_valid = 0;
    @(negedge clk);
    rst = 0;
    // Entries restart at 01, so one taken resolve raises the prediction
    drv(3'd1, 64'h10, 0, 0, 0, 0, 0, 0, 0);
    chk("arst_weak_nt", 64'(m_bht[4]), 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
